// File: rtl/debug_pulse_scheduler.sv
// Round-robin scheduler that shares one scope probe pin between debug
// event sources, emitting one stretched pulse per latched event.
//
// Ports:
//   clk            : system clock, rising edge
//   nReset         : asynchronous active-low reset
//   enable         : gates new grants; a pulse in progress always completes
//   event_in       : per-source event strobes (rising edge = one event)
//   clear_overflow : single-cycle clear of the sticky overflow flags
//   scope_pulse    : registered stretched pulse (STRETCH cycles high)
//   scope_id       : registered index of the source being / last served
//   pending        : per-source pending flags
//   overflow       : sticky per-source "event lost" flags
//   busy           : high while a pulse or its trailing gap is running
module debug_pulse_scheduler #(
    parameter int NUM_SRC = 4,
    parameter int ID_W    = 2,
    parameter int STRETCH = 10,
    parameter int GAP     = 2
) (
    input  logic               clk,
    input  logic               nReset,
    input  logic               enable,
    input  logic [NUM_SRC-1:0] event_in,
    input  logic               clear_overflow,
    output logic               scope_pulse,
    output logic [ID_W-1:0]    scope_id,
    output logic [NUM_SRC-1:0] pending,
    output logic [NUM_SRC-1:0] overflow,
    output logic               busy
);

    localparam int MAX_CNT = (STRETCH > GAP) ? STRETCH : GAP;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    // Elaboration-time parameter sanity checks
    if (NUM_SRC < 2 || NUM_SRC > 16) begin : g_bad_num_src
        $error("debug_pulse_scheduler: NUM_SRC must be 2..16");
    end
    if ((2 ** ID_W) < NUM_SRC) begin : g_bad_id_w
        $error("debug_pulse_scheduler: ID_W too narrow for NUM_SRC");
    end
    if (STRETCH < 1) begin : g_bad_stretch
        $error("debug_pulse_scheduler: STRETCH must be >= 1");
    end
    if (GAP < 0) begin : g_bad_gap
        $error("debug_pulse_scheduler: GAP must be >= 0");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PULSE,
        ST_GAP
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               r_pulse;
    logic               w_pulse_nxt;
    logic [ID_W-1:0]    r_id;
    logic [ID_W-1:0]    w_id_nxt;
    logic [ID_W-1:0]    r_last;
    logic [ID_W-1:0]    w_last_nxt;
    logic               r_busy;

    logic [NUM_SRC-1:0] r_prev;
    logic [NUM_SRC-1:0] r_pending;
    logic [NUM_SRC-1:0] r_overflow;

    logic [NUM_SRC-1:0] w_rise;
    logic               w_found;
    logic [ID_W-1:0]    w_gnt_idx;
    logic               w_gnt_valid;
    logic [NUM_SRC-1:0] w_gnt_vec;
    logic [NUM_SRC-1:0] w_ovf_set;

    assign w_rise = event_in & ~r_prev;

    // Round-robin search starting just after the last granted source
    always_comb begin : p_arb
        int v_sum;
        logic [ID_W-1:0] v_idx;
        v_sum     = 0;
        v_idx     = '0;
        w_found   = 1'b0;
        w_gnt_idx = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            v_sum = int'(r_last) + k;
            if (v_sum >= NUM_SRC) begin
                v_sum = v_sum - NUM_SRC;
            end
            v_idx = ID_W'(v_sum);
            if (!w_found && r_pending[v_idx]) begin
                w_found   = 1'b1;
                w_gnt_idx = v_idx;
            end
        end
    end

    assign w_gnt_valid = (r_state == ST_IDLE) && enable && w_found;
    assign w_gnt_vec   = w_gnt_valid ? (NUM_SRC'(1) << w_gnt_idx) : '0;

    // A repeat event is lost only if the earlier one is still queued and
    // not being served right now.
    assign w_ovf_set = w_rise & r_pending & ~w_gnt_vec;

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_prev     <= '0;
            r_pending  <= '0;
            r_overflow <= '0;
        end else begin
            r_prev     <= event_in;
            // rise keeps/sets pending even when granted this cycle
            r_pending  <= (r_pending & ~w_gnt_vec) | w_rise;
            r_overflow <= (clear_overflow ? '0 : r_overflow) | w_ovf_set;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pulse_nxt = r_pulse;
        w_id_nxt    = r_id;
        w_last_nxt  = r_last;
        unique case (r_state)
            ST_IDLE: begin
                if (w_gnt_valid) begin
                    w_id_nxt    = w_gnt_idx;
                    w_last_nxt  = w_gnt_idx;
                    w_pulse_nxt = 1'b1;
                    w_cnt_nxt   = CNT_W'(STRETCH - 1);
                    w_state_nxt = ST_PULSE;
                end
            end
            ST_PULSE: begin
                if (r_cnt == '0) begin
                    w_pulse_nxt = 1'b0;
                    if (GAP > 0) begin
                        w_cnt_nxt   = CNT_W'(GAP - 1);
                        w_state_nxt = ST_GAP;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_pulse_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_pulse <= 1'b0;
            r_id    <= '0;
            r_last  <= ID_W'(NUM_SRC - 1);
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_pulse <= w_pulse_nxt;
            r_id    <= w_id_nxt;
            r_last  <= w_last_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
        end
    end

    assign scope_pulse = r_pulse;
    assign scope_id    = r_id;
    assign pending     = r_pending;
    assign overflow    = r_overflow;
    assign busy        = r_busy;

endmodule

// File: tb/tb_debug_pulse_scheduler.sv
// Directed testbench for debug_pulse_scheduler (default parameters).
// Table-driven per-cycle vectors plus hand-written multi-cycle sequences.
module tb_debug_pulse_scheduler;

    logic       clk = 1'b0;
    logic       nReset;
    logic       enable;
    logic [3:0] event_in;
    logic       clear_overflow;
    logic       scope_pulse;
    logic [1:0] scope_id;
    logic [3:0] pending;
    logic [3:0] overflow;
    logic       busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    debug_pulse_scheduler #(
        .NUM_SRC(4),
        .ID_W(2),
        .STRETCH(10),
        .GAP(2)
    ) dut (
        .clk(clk),
        .nReset(nReset),
        .enable(enable),
        .event_in(event_in),
        .clear_overflow(clear_overflow),
        .scope_pulse(scope_pulse),
        .scope_id(scope_id),
        .pending(pending),
        .overflow(overflow),
        .busy(busy)
    );

    typedef struct {
        logic [3:0] ev;
        logic       en;
        logic       clr;
        logic       pulse;
        logic [1:0] id;
        logic [3:0] pend;
        logic [3:0] ovf;
        logic       bsy;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic add(input int n, input logic [3:0] ev, input logic en,
                       input logic clr, input logic pulse,
                       input logic [1:0] id, input logic [3:0] pend,
                       input logic [3:0] ovf, input logic bsy);
        vec_t v;
        v.ev = ev; v.en = en; v.clr = clr; v.pulse = pulse;
        v.id = id; v.pend = pend; v.ovf = ovf; v.bsy = bsy;
        for (int i = 0; i < n; i++) tbl.push_back(v);
    endtask

    // drive at negedge, sample 1 time unit after the following posedge
    task automatic cyc(input logic [3:0] ev, input logic en, input logic clr);
        @(negedge clk);
        event_in       = ev;
        enable         = en;
        clear_overflow = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        nReset         = 1'b0;
        event_in       = '0;
        enable         = 1'b1;
        clear_overflow = 1'b0;
        #2;
        chk({tag, ".rst_pulse"}, scope_pulse, 0);
        chk({tag, ".rst_id"}, scope_id, 0);
        chk({tag, ".rst_pend"}, pending, 0);
        chk({tag, ".rst_ovf"}, overflow, 0);
        chk({tag, ".rst_busy"}, busy, 0);
        @(negedge clk);
        nReset = 1'b1;
    endtask

    task automatic run_table(input string tag);
        foreach (tbl[i]) begin
            cyc(tbl[i].ev, tbl[i].en, tbl[i].clr);
            chk($sformatf("%s[%0d].pulse", tag, i), scope_pulse, tbl[i].pulse);
            chk($sformatf("%s[%0d].id", tag, i), scope_id, tbl[i].id);
            chk($sformatf("%s[%0d].pend", tag, i), pending, tbl[i].pend);
            chk($sformatf("%s[%0d].ovf", tag, i), overflow, tbl[i].ovf);
            chk($sformatf("%s[%0d].busy", tag, i), busy, tbl[i].bsy);
        end
        tbl.delete();
    endtask

    initial begin
        int cnt;
        int rises;
        logic prev_p;

        nReset         = 1'b0;
        enable         = 1'b0;
        event_in       = '0;
        clear_overflow = 1'b0;

        // ---- single event on source 2 ----
        do_reset("single");
        add(1, 4'b0000, 1, 0, 0, 0, 4'b0000, 0, 0);
        add(1, 4'b0100, 1, 0, 0, 0, 4'b0100, 0, 0);
        add(10, 4'b0000, 1, 0, 1, 2, 4'b0000, 0, 1);
        add(2, 4'b0000, 1, 0, 0, 2, 4'b0000, 0, 1);
        add(2, 4'b0000, 1, 0, 0, 2, 4'b0000, 0, 0);
        run_table("single");

        // ---- simultaneous events 1011 -> grants 0,1,3 ----
        do_reset("multi");
        add(1, 4'b1011, 1, 0, 0, 0, 4'b1011, 0, 0);
        add(10, 4'b0000, 1, 0, 1, 0, 4'b1010, 0, 1);
        add(2, 4'b0000, 1, 0, 0, 0, 4'b1010, 0, 1);
        add(1, 4'b0000, 1, 0, 0, 0, 4'b1010, 0, 0);
        add(10, 4'b0000, 1, 0, 1, 1, 4'b1000, 0, 1);
        add(2, 4'b0000, 1, 0, 0, 1, 4'b1000, 0, 1);
        add(1, 4'b0000, 1, 0, 0, 1, 4'b1000, 0, 0);
        add(10, 4'b0000, 1, 0, 1, 3, 4'b0000, 0, 1);
        add(2, 4'b0000, 1, 0, 0, 3, 4'b0000, 0, 1);
        add(2, 4'b0000, 1, 0, 0, 3, 4'b0000, 0, 0);
        run_table("multi");

        // ---- overflow on source 1 during a source 0 pulse ----
        do_reset("ovf");
        cyc(4'b0001, 1, 0);
        cyc(4'b0000, 1, 0);
        chk("ovf.grant0", {scope_pulse, scope_id}, {1'b1, 2'd0});
        cyc(4'b0010, 1, 0);
        chk("ovf.first_pend", pending, 4'b0010);
        chk("ovf.first_noovf", overflow, 4'b0000);
        cyc(4'b0000, 1, 0);
        cyc(4'b0010, 1, 0);
        chk("ovf.set", overflow, 4'b0010);
        chk("ovf.pend", pending, 4'b0010);
        cyc(4'b0000, 1, 0);
        rises  = 0;
        prev_p = scope_pulse;
        for (int i = 0; i < 40; i++) begin
            cyc(4'b0000, 1, 0);
            if (scope_pulse && !prev_p && scope_id == 2'd1) rises++;
            prev_p = scope_pulse;
        end
        chk("ovf.src1_pulses", rises, 1);
        chk("ovf.sticky", overflow, 4'b0010);
        chk("ovf.idle_pend", pending, 4'b0000);
        cyc(4'b0000, 1, 1);
        chk("ovf.cleared", overflow, 4'b0000);
        // clear and new overflow in the same cycle: set wins
        cyc(4'b0100, 0, 0);
        cyc(4'b0000, 0, 0);
        cyc(4'b0100, 0, 1);
        chk("ovf.set_wins", overflow, 4'b0100);

        // ---- rise on source 0 in its own grant cycle ----
        do_reset("regrant");
        cyc(4'b0001, 0, 0);
        cyc(4'b0000, 0, 0);
        chk("regrant.held", {busy, pending}, {1'b0, 4'b0001});
        cyc(4'b0001, 1, 0);
        chk("regrant.pulse", {scope_pulse, scope_id}, {1'b1, 2'd0});
        chk("regrant.pend", pending, 4'b0001);
        chk("regrant.noovf", overflow, 4'b0000);
        for (int i = 0; i < 12; i++) cyc(4'b0000, 1, 0);
        chk("regrant.idle", {scope_pulse, busy, pending}, {2'b00, 4'b0001});
        cyc(4'b0000, 1, 0);
        chk("regrant.second", {scope_pulse, scope_id, pending},
            {1'b1, 2'd0, 4'b0000});

        // ---- enable gating ----
        do_reset("en");
        cyc(4'b0100, 0, 0);
        for (int i = 0; i < 3; i++) cyc(4'b0000, 0, 0);
        chk("en.blocked", {scope_pulse, busy, pending}, {2'b00, 4'b0100});
        cyc(4'b0000, 1, 0);
        chk("en.start", {scope_pulse, scope_id}, {1'b1, 2'd2});
        cnt = 1;
        for (int i = 0; i < 2; i++) begin
            cyc(4'b0000, 1, 0);
            if (scope_pulse) cnt++;
        end
        for (int i = 0; i < 15; i++) begin
            cyc(4'b0000, 0, 0);
            if (scope_pulse) cnt++;
        end
        chk("en.width", cnt, 10);
        chk("en.done", {scope_pulse, busy}, 2'b00);

        // ---- asynchronous reset mid-pulse ----
        do_reset("arst");
        cyc(4'b0100, 1, 0);
        cyc(4'b1011, 1, 0);
        chk("arst.pulse_on", {scope_pulse, scope_id}, {1'b1, 2'd2});
        cyc(4'b0000, 1, 0);
        cyc(4'b0000, 1, 0);
        cyc(4'b0000, 1, 0);
        #2;
        nReset = 1'b0;
        #1;
        chk("arst.pulse", scope_pulse, 0);
        chk("arst.pend", pending, 0);
        chk("arst.busy", busy, 0);
        chk("arst.id", scope_id, 0);
        @(negedge clk);
        nReset = 1'b1;
        cyc(4'b1111, 1, 0);
        chk("arst.all_pend", pending, 4'b1111);
        cyc(4'b0000, 1, 0);
        chk("arst.first0", {scope_pulse, scope_id, pending},
            {1'b1, 2'd0, 4'b1110});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/debug_pulse_scheduler.md
Name: debug_pulse_scheduler

Overview:
- Shares one debug scope probe channel between NUM_SRC single-cycle debug event sources.
- Each rising edge on a source is latched as pending.
- Pending sources are served round-robin. Each grant emits one stretched pulse of exactly STRETCH cycles, followed by GAP idle cycles, and presents the served source index on scope_id.
- The block sits between internal debug strobes and the scope header, so the DSO can capture short events from several sources on a few pins.

Parameters:
- NUM_SRC, 4, number of event sources (2..16).
- ID_W, 2, width of scope_id. Must satisfy 2**ID_W >= NUM_SRC.
- STRETCH, 10, pulse high time in clk cycles (>= 1).
- GAP, 2, minimum low time between consecutive pulses in clk cycles (>= 0).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- nReset  input  1  asynchronous, active-low reset.
- enable  input  1  when low, no new grant starts; a pulse in progress completes.
- event_in  input  NUM_SRC  event strobes, synchronous to clk; any width.
- clear_overflow  input  1  single-cycle clear of overflow.
- scope_pulse  output  1  stretched pulse, registered.
- scope_id  output  ID_W  index of the source being / last served, registered.
- pending  output  NUM_SRC  per-source pending flags.
- overflow  output  NUM_SRC  sticky per-source "event lost" flags.
- busy  output  1  high while the FSM is in PULSE or GAP.

Behaviour:
- Reset:
  - Asynchronous, active-low. Applies immediately, including mid-pulse.
  - scope_pulse=0, scope_id=0, pending=0, overflow=0, busy=0.
  - Edge-detect history = 0, FSM = IDLE, counter = 0.
  - Round-robin pointer last_grant = NUM_SRC-1, so source 0 has first priority.
- Edge detect:
  - Per source, rise[i] = event_in[i] & ~prev[i]; prev is registered every cycle.
  - A level held high produces one event only.
- Pending and overflow update, per source, each cycle:
  - If rise[i], pending[i] <= 1.
    - overflow[i] <= 1 only if pending[i] was already 1 and source i is not granted this cycle.
    - If source i is granted in the same cycle as rise[i], pending[i] stays 1 (new event queued) with no overflow.
  - Else if granted this cycle, pending[i] <= 0.
  - clear_overflow zeroes all overflow bits. If clear_overflow and a new overflow condition occur in the same cycle, the set wins.
- FSM:
  - IDLE:
    - If enable and pending != 0, grant g = first set pending bit searching upward from last_grant+1, wrapping modulo NUM_SRC.
    - On the grant edge: scope_id <= g, last_grant <= g, clear pending[g], scope_pulse <= 1, counter <= STRETCH-1, go to PULSE.
  - PULSE:
    - scope_pulse stays 1.
    - counter == 0: scope_pulse <= 0. If GAP > 0, counter <= GAP-1 and go to GAP; else go to IDLE.
    - Otherwise counter decrements.
  - GAP:
    - scope_pulse stays 0.
    - counter == 0: go to IDLE. Otherwise counter decrements.
  - busy = (state != IDLE), registered alongside the state.
- Timing:
  - scope_pulse is high for exactly STRETCH cycles.
  - With continuous pending requests, the pulse period is STRETCH + GAP + 1 cycles; IDLE takes one cycle for arbitration.
  - Latency: event_in rises at edge k → pending visible after edge k → scope_pulse high after edge k+1, if idle and enabled.
- scope_id holds its value through GAP and IDLE until the next grant.
- Counter width is clog2(max(STRETCH, GAP) + 1).
- Out-of-range parameters are a synthesis-time error via a generate-time check.

Test Plan:
- Single event, defaults: one-cycle pulse on event_in[2] at edge 5 → pending[2]=1 after edge 5; scope_pulse high for edges 6..15 (10 cycles); scope_id=2; busy low after edge 18; overflow=0.
- Simultaneous events: event_in=4'b1011 for one cycle → grants in order 0, 1, 3, each a 10-cycle pulse separated by 3 low cycles (GAP=2 + IDLE); pending clears bit by bit; final scope_id=3.
- Overflow: two rising edges on source 1 while a source 0 pulse is in progress → overflow[1]=1 and only one pulse for source 1. Then clear_overflow → overflow=0.
- Same-cycle grant and re-event: rise on source 0 in the cycle it is granted → pending[0] remains 1, overflow[0]=0, and a second pulse for 0 follows after the gap.
- Enable gating: enable=0 with pending=4'b0100 → no pulse, busy=0. Raising enable → pulse starts on the next edge. Dropping enable mid-pulse → that pulse still lasts 10 cycles.
- Reset mid-pulse: assert nReset low at cycle 4 of a pulse → scope_pulse=0 and pending=0 immediately, without waiting for a clk edge. After release, the first grant goes to source 0 when all sources are pending.
